thermometer_count_decoder: RTL and testbench
============================================

# thermometer_count_decoder

Streaming decoder that converts a thermometer bitmask (N least-significant bits set) back into the integer N. It is the inverse of the count-to-thermometer bitmask generator. It sits on valid/ready interfaces between a mask-producing stage (priority/arbiter logic, FIFO fill indicators) and count-consuming logic. It is a 2-stage pipeline with full throughput, backpressure, and a malformed-mask error flag.

## Interface
- WORD_WIDTH, default 8: thermometer width; legal values are 1 and above.
- COUNT_WIDTH, derived as clog2(WORD_WIDTH+1), not overridable: width needed to represent 0..WORD_WIDTH.
- clock  in  1  single clock; all state updates on the rising edge.
- areset_n  in  1  reset, asynchronous assert, active-low. Deassertion is synchronised externally.
- input_valid  in  1  input_data is presented.
- input_ready  out  1  block accepts input_data this cycle.
- input_data  in  WORD_WIDTH  thermometer mask.
- output_valid  out  1  output_count and output_error are valid.
- output_ready  in  1  downstream accepts the output this cycle.
- output_count  out  COUNT_WIDTH  number of contiguous set bits starting at bit 0.
- output_error  out  1  input_data was not a legal thermometer code.

## Operation
- Transfer rule: a transfer occurs on any cycle where valid and ready are both 1, at either port.
- Count definition: count is the number of trailing ones in input_data.
  - The lowest clear bit is isolated as onehot = (input_data + 1) & ~input_data, computed in WORD_WIDTH+1 bits.
  - If input_data is all ones, onehot has bit WORD_WIDTH set, giving count = WORD_WIDTH.
  - output_count is the bit index of the single set bit in onehot.
- Legality: the mask is legal iff (input_data & (input_data + 1)) == 0 in WORD_WIDTH+1 bits.
  - If illegal, output_error = 1 and output_count still equals the trailing-ones count. Example: 0b0101 gives count 1, error 1.
- All-zeros input: count 0, error 0.
- Stage 1 registers:
  - s1_valid;
  - the onehot vector (WORD_WIDTH+1 bits);
  - s1_error.
- Stage 2 registers:
  - output_valid;
  - output_count, the one-hot-to-binary encoding of onehot;
  - output_error.
- Advance conditions:
  - s2_advance = !output_valid || output_ready.
  - s1_advance = !s1_valid || s2_advance.
  - input_ready = s1_advance. This is a combinational path from output_ready; no skid buffer.
- Valid propagation on each clock edge:
  - If s2_advance: output_valid <= s1_valid, and the stage 2 data loads.
  - If s1_advance: s1_valid <= input_valid, and the stage 1 data loads.
- Data stability: data registers load only when their stage advances. Held outputs stay stable while output_valid=1 and output_ready=0.

## Timing
- Reset values on areset_n=0, applied immediately:
  - s1_valid = 0, output_valid = 0;
  - output_count = 0, output_error = 0;
  - onehot = 0, s1_error = 0.
  - input_ready is therefore 1 during reset.
- Latency: a word accepted at edge k appears with output_valid=1 after edge k+1. That is 2 register stages, visible in the cycle after the second edge.
- Throughput: one word per cycle while output_ready=1.
- Backpressure:
  - With output_ready=0 and both stages full, input_ready=0 in the same cycle.
  - No data is lost or duplicated.
  - At most 2 words are in flight.
- Simultaneous output drain and input accept in the same cycle: both transfers complete.
- Reset mid-operation: in-flight words are discarded. No output_valid pulse occurs until new input is accepted after areset_n returns high.

## Structure
- Shared package/include: a clog2 constant function, used for COUNT_WIDTH; no typedefs.
- One sub-module: onehot_to_binary, with parameter ONEHOT_WIDTH=WORD_WIDTH+1. It is purely combinational and maps the single set bit to its index, giving 0 for all-zeros input.
- The pipeline control logic stays in the top module.

## Test plan
All scenarios use WORD_WIDTH=8 (COUNT_WIDTH=4).
- Basic decode: inputs 0x00, 0x01, 0x07, 0x7F, 0xFF with output_ready=1 held -> counts 0, 1, 3, 7, 8, error 0 throughout, each appearing 2 cycles after acceptance.
- Malformed masks: 0x05 -> count 1, error 1. 0x80 -> count 0, error 1. 0xFE -> count 0, error 1.
- Backpressure: stream 0x03, 0x0F, 0x3F with output_ready=0 for 4 cycles, then 1:
  - input_ready drops after 2 accepts;
  - outputs are 2, 4, 6 in order, with none lost or duplicated;
  - held output is stable while stalled.
- Full-rate stream: 16 random legal masks back-to-back with output_ready=1 -> 16 consecutive output_valid cycles with matching counts.
- Reset: assert areset_n=0 with 2 words in flight -> output_valid=0 immediately. After release, the first output is the first word accepted post-reset.
- Random toggling of input_valid and output_ready over 1000 cycles -> outputs match a scoreboard model in order, with output data stable while stalled.

Source files
------------

// File: rtl/thermometer_count_decoder_pkg.sv
// Shared constants and helpers for the thermometer-to-count decoder.
package thermometer_count_decoder_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 32'sd0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 32'sd1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/thermometer_count_decoder_onehot_to_binary.sv
// Combinational one-hot to binary index encoder; all-zeros maps to index 0.
module onehot_to_binary
    import thermometer_count_decoder_pkg::*;
#(
    parameter int  ONEHOT_WIDTH = 9,
    localparam int INDEX_WIDTH  = (clog2(ONEHOT_WIDTH) > 0) ? clog2(ONEHOT_WIDTH) : 1
) (
    input  logic [ONEHOT_WIDTH-1:0] onehot,
    output logic [INDEX_WIDTH-1:0]  index
);

    // OR together the indices of all set bits; exact for a single set bit
    always_comb begin
        index = '0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot[i]) begin
                index = index | INDEX_WIDTH'(i);
            end else begin
                index = index;
            end
        end
    end

endmodule

// File: rtl/thermometer_count_decoder.sv
// Two-stage valid/ready pipeline turning a thermometer mask into its trailing-ones count,
// flagging masks that are not a legal thermometer code.
module thermometer_count_decoder
    import thermometer_count_decoder_pkg::*;
#(
    parameter int  WORD_WIDTH  = 8,
    localparam int COUNT_WIDTH = clog2(WORD_WIDTH + 1)
) (
    input  logic                   clock,
    input  logic                   areset_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_data,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [COUNT_WIDTH-1:0] output_count,
    output logic                   output_error
);

    logic [WORD_WIDTH:0]  data_ext_s;
    logic [WORD_WIDTH:0]  plus_one_s;
    logic [WORD_WIDTH:0]  onehot_s;
    logic                 malformed_s;
    logic                 s2_advance_s;
    logic                 s1_advance_s;
    logic                 s1_valid_r;
    logic [WORD_WIDTH:0]  onehot_r;
    logic                 s1_error_r;
    logic [COUNT_WIDTH-1:0] count_s;

    // Extra top bit lets an all-ones mask carry into bit WORD_WIDTH
    assign data_ext_s   = {1'b0, input_data};
    assign plus_one_s   = data_ext_s + {{WORD_WIDTH{1'b0}}, 1'b1};
    assign onehot_s     = plus_one_s & ~data_ext_s;
    assign malformed_s  = |(data_ext_s & plus_one_s);

    assign s2_advance_s = ~output_valid | output_ready;
    assign s1_advance_s = ~s1_valid_r | s2_advance_s;
    assign input_ready  = s1_advance_s;

    onehot_to_binary #(
        .ONEHOT_WIDTH(WORD_WIDTH + 1)
    ) u_encoder (
        .onehot(onehot_r),
        .index (count_s)
    );

    // Stage 1: capture the isolated lowest-clear bit and the legality flag
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            s1_valid_r <= 1'b0;
            onehot_r   <= '0;
            s1_error_r <= 1'b0;
        end else if (s1_advance_s) begin
            s1_valid_r <= input_valid;
            onehot_r   <= onehot_s;
            s1_error_r <= malformed_s;
        end
    end

    // Stage 2: registered outputs, held while downstream stalls
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            output_valid <= 1'b0;
            output_count <= '0;
            output_error <= 1'b0;
        end else if (s2_advance_s) begin
            output_valid <= s1_valid_r;
            output_count <= count_s;
            output_error <= s1_error_r;
        end
    end

endmodule

// File: tb/tb_thermometer_count_decoder.sv
// Directed and randomised self-checking bench for thermometer_count_decoder (WORD_WIDTH=8).
module tb_thermometer_count_decoder;

    logic       clock;
    logic       areset_n;
    logic       input_valid;
    logic       input_ready;
    logic [7:0] input_data;
    logic       output_valid;
    logic       output_ready;
    logic [3:0] output_count;
    logic       output_error;

    thermometer_count_decoder #(.WORD_WIDTH(8)) dut (
        .clock       (clock),
        .areset_n    (areset_n),
        .input_valid (input_valid),
        .input_ready (input_ready),
        .input_data  (input_data),
        .output_valid(output_valid),
        .output_ready(output_ready),
        .output_count(output_count),
        .output_error(output_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] data;
        logic [3:0] count;
        logic       err;
    } vec_t;

    vec_t       tbl [12];
    logic [4:0] sb [$];
    int         checks;
    int         errors;
    int         pops;
    int         run;
    int         max_run;
    logic       prev_stall;
    logic [3:0] prev_count;
    logic       prev_err;

    function automatic logic [3:0] model_count(input logic [7:0] d);
        int n;
        n = 0;
        while (n < 8 && d[n]) n++;
        return 4'(n);
    endfunction

    function automatic logic model_err(input logic [7:0] d);
        logic e;
        int   n;
        e = 1'b0;
        n = int'(model_count(d));
        for (int i = n; i < 8; i++) begin
            if (d[i]) e = 1'b1;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: sample handshakes at negedge, check against scoreboard, advance
    task automatic tick(output logic acc);
        @(negedge clock);
        acc = input_valid && input_ready;
        if (prev_stall) begin
            chk("hold_valid", 32'(output_valid), 32'd1);
            chk("hold_count", 32'(output_count), 32'(prev_count));
            chk("hold_err", 32'(output_error), 32'(prev_err));
        end
        if (output_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got output_valid=1 with nothing in flight at %0t", $time);
            end else begin
                chk("sb_count", 32'(output_count), 32'(sb[0][3:0]));
                chk("sb_err", 32'(output_error), 32'(sb[0][4]));
                if (output_ready) begin
                    void'(sb.pop_front());
                    pops++;
                end
            end
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        prev_stall = output_valid && !output_ready;
        prev_count = output_count;
        prev_err   = output_error;
        if (acc) sb.push_back({model_err(input_data), model_count(input_data)});
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic acc;
        int   k;
        int   pops0;
        checks = 0; errors = 0; pops = 0; run = 0; max_run = 0;
        prev_stall = 1'b0; prev_count = 4'd0; prev_err = 1'b0;

        tbl[0]  = '{8'h00, 4'd0, 1'b0};
        tbl[1]  = '{8'h01, 4'd1, 1'b0};
        tbl[2]  = '{8'h07, 4'd3, 1'b0};
        tbl[3]  = '{8'h7F, 4'd7, 1'b0};
        tbl[4]  = '{8'hFF, 4'd8, 1'b0};
        tbl[5]  = '{8'h05, 4'd1, 1'b1};
        tbl[6]  = '{8'h80, 4'd0, 1'b1};
        tbl[7]  = '{8'hFE, 4'd0, 1'b1};
        tbl[8]  = '{8'h03, 4'd2, 1'b0};
        tbl[9]  = '{8'h0F, 4'd4, 1'b0};
        tbl[10] = '{8'h1F, 4'd5, 1'b0};
        tbl[11] = '{8'hB7, 4'd3, 1'b1};

        areset_n = 1'b0; input_valid = 1'b0; input_data = 8'h00; output_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(output_valid), 32'd0);
        chk("rst_count", 32'(output_count), 32'd0);
        chk("rst_err", 32'(output_error), 32'd0);
        chk("rst_in_ready", 32'(input_ready), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        areset_n = 1'b1;

        // Table: each word checked exactly two edges after acceptance
        for (int i = 0; i < 12; i++) begin
            input_valid = 1'b1;
            input_data  = tbl[i].data;
            tick(acc);
            chk("tbl_accept", 32'(acc), 32'd1);
            input_valid = 1'b0;
            chk("tbl_lat_early", 32'(output_valid), 32'd0);
            tick(acc);
            chk("tbl_valid", 32'(output_valid), 32'd1);
            chk("tbl_count", 32'(output_count), 32'(tbl[i].count));
            chk("tbl_err", 32'(output_error), 32'(tbl[i].err));
        end
        tick(acc);
        chk("tbl_drained", 32'(sb.size()), 32'd0);

        // Backpressure: two accepts fill the pipe, third word waits
        pops0 = pops;
        output_ready = 1'b0;
        input_valid = 1'b1; input_data = 8'h03;
        tick(acc);
        chk("bp_acc1", 32'(acc), 32'd1);
        input_data = 8'h0F;
        tick(acc);
        chk("bp_acc2", 32'(acc), 32'd1);
        input_data = 8'h3F;
        chk("bp_ready_low", 32'(input_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick(acc);
            chk("bp_stall_acc", 32'(acc), 32'd0);
            chk("bp_stall_count", 32'(output_count), 32'd2);
        end
        output_ready = 1'b1;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 5) begin
            tick(acc);
            k++;
        end
        chk("bp_acc3", 32'(acc), 32'd1);
        input_valid = 1'b0;
        k = 0;
        while (sb.size() > 0 && k < 10) begin
            tick(acc);
            k++;
        end
        chk("bp_pops", 32'(pops - pops0), 32'd3);

        // Full-rate stream of random legal masks
        pops0 = pops;
        max_run = 0;
        for (int i = 0; i < 16; i++) begin
            input_valid = 1'b1;
            input_data  = 8'((9'h001 << $urandom_range(0, 8)) - 9'h001);
            tick(acc);
            chk("fr_accept", 32'(acc), 32'd1);
        end
        input_valid = 1'b0;
        repeat (3) tick(acc);
        chk("fr_pops", 32'(pops - pops0), 32'd16);
        chk("fr_run", 32'(max_run), 32'd16);

        // Reset with two words in flight
        output_ready = 1'b0;
        input_valid = 1'b1; input_data = 8'h01;
        tick(acc);
        input_data = 8'h03;
        tick(acc);
        input_valid = 1'b0;
        chk("mr_full", 32'(output_valid), 32'd1);
        areset_n = 1'b0;
        #1;
        chk("mr_out_valid", 32'(output_valid), 32'd0);
        chk("mr_in_ready", 32'(input_ready), 32'd1);
        sb.delete();
        prev_stall = 1'b0;
        run = 0;
        @(posedge clock);
        #1;
        areset_n = 1'b1;
        output_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            chk("mr_quiet", 32'(output_valid), 32'd0);
        end
        input_valid = 1'b1; input_data = 8'h1F;
        tick(acc);
        input_valid = 1'b0;
        tick(acc);
        chk("mr_first_valid", 32'(output_valid), 32'd1);
        chk("mr_first_count", 32'(output_count), 32'd5);
        tick(acc);

        // Random valid/ready toggling against the scoreboard
        for (int i = 0; i < 1000; i++) begin
            input_valid  = 1'($urandom_range(0, 1));
            input_data   = 8'($urandom);
            output_ready = 1'($urandom_range(0, 1));
            tick(acc);
        end
        input_valid = 1'b0;
        output_ready = 1'b1;
        k = 0;
        while (sb.size() > 0 && k < 10) begin
            tick(acc);
            k++;
        end
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rand_idle", 32'(output_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
